// File: rtl/tpm_crb_pkg.sv
// Shared constants, state encoding and helpers for the CRB command/response engine.
package tpm_crb_pkg;

  // TPM response codes produced by the engine itself
  localparam logic [31:0] RC_SUCCESS      = 32'h0000_0000;
  localparam logic [31:0] RC_COMMAND_SIZE = 32'h0000_0142;
  localparam logic [31:0] RC_BAD_TAG      = 32'h0000_001E;
  localparam logic [31:0] RC_LOCALITY     = 32'h0000_0907;

  // Command/response tags
  localparam logic [15:0] TAG_NO_SESSIONS = 16'h8001;
  localparam logic [15:0] TAG_SESSIONS    = 16'h8002;

  // Fixed TPM header length in bytes (tag + size + code/rc)
  localparam int HDR_LEN = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CHECK,
    ST_EXEC,
    ST_RSP_HDR,
    ST_RSP_PAY,
    ST_DONE,
    ST_ABORT
  } state_e;

  // Byte i (0 = most significant) of a big-endian 32-bit word
  function automatic logic [7:0] be_byte(input logic [31:0] w, input logic [1:0] i);
    logic [7:0] b;
    case (i)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/crb_byte_seq.sv
// Start/count address sequencer for a buffer with 1-cycle read latency.
// Issues addresses 0..count-1 on consecutive cycles and reports the matching
// captured index one cycle later. count_i must be non-zero when start_i fires.
module crb_byte_seq #(
  parameter int AW = 12
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start_i,
  input  logic          clear_i,
  input  logic [AW-1:0] count_i,
  output logic          rd_en_o,
  output logic [AW-1:0] rd_addr_o,
  output logic          cap_valid_o,
  output logic [AW-1:0] cap_idx_o,
  output logic          last_o
);

  logic          active_q, active_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] last_q, last_d;
  logic          vld_q, vld_d;
  logic [AW-1:0] idx_q, idx_d;

  // Next-state: address advances while active and holds at the last address (no wrap)
  always_comb begin
    active_d = active_q;
    addr_d   = addr_q;
    last_d   = last_q;
    vld_d    = active_q;
    idx_d    = addr_q;
    if (clear_i) begin
      active_d = 1'b0;
      vld_d    = 1'b0;
    end else if (start_i) begin
      active_d = 1'b1;
      addr_d   = '0;
      last_d   = count_i - AW'(1);
    end else if (active_q) begin
      if (addr_q == last_q) begin
        active_d = 1'b0;
      end else begin
        addr_d = addr_q + AW'(1);
      end
    end
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      active_q <= 1'b0;
      addr_q   <= '0;
      last_q   <= '0;
      vld_q    <= 1'b0;
      idx_q    <= '0;
    end else begin
      active_q <= active_d;
      addr_q   <= addr_d;
      last_q   <= last_d;
      vld_q    <= vld_d;
      idx_q    <= idx_d;
    end
  end

  assign rd_en_o     = active_q;
  assign rd_addr_o   = addr_q;
  assign cap_valid_o = vld_q;
  assign cap_idx_o   = idx_q;
  assign last_o      = vld_q && (idx_q == last_q);

endmodule

// File: rtl/tpm_crb_engine.sv
// CRB command/response engine: fetches and validates a command, hands it to the
// execution unit, then writes a header plus copied payload into the response buffer.
module tpm_crb_engine
  import tpm_crb_pkg::*;
#(
  parameter int BUF_AW      = 12,
  parameter int NUM_LOC     = 5,
  parameter int PARAM_BYTES = 5
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     cmd_start,
  input  logic [31:0]              cmd_size,
  input  logic [2:0]               locality,
  input  logic                     cmd_abort,
  output logic                     cmd_rd_en,
  output logic [BUF_AW-1:0]        cmd_rd_addr,
  input  logic [7:0]               cmd_rd_data,
  output logic                     exec_req,
  output logic [15:0]              exec_tag,
  output logic [31:0]              exec_code,
  output logic [2:0]               exec_locality,
  output logic [8*PARAM_BYTES-1:0] exec_param,
  input  logic                     exec_ack,
  input  logic [31:0]              exec_rc,
  input  logic [BUF_AW-1:0]        exec_rsp_len,
  output logic [BUF_AW-1:0]        pl_rd_addr,
  input  logic [7:0]               pl_rd_data,
  output logic                     rsp_wr_en,
  output logic [BUF_AW-1:0]        rsp_wr_addr,
  output logic [7:0]               rsp_wr_data,
  output logic [31:0]              rsp_size,
  output logic                     busy,
  output logic                     done,
  output logic                     aborted
);

  localparam int                DEPTH     = 2 ** BUF_AW;
  localparam int                FETCH_MAX = HDR_LEN + PARAM_BYTES;
  localparam int                PW        = 8 * PARAM_BYTES;
  localparam logic [32:0]       DEPTH_W   = 33'(DEPTH);
  localparam logic [BUF_AW-1:0] LEN_MAX   = BUF_AW'(DEPTH - HDR_LEN);

  state_e            state_q, state_d;
  logic [31:0]       size_q, size_d;
  logic [2:0]        loc_q, loc_d;
  logic [15:0]       tag_q, tag_d;
  logic [31:0]       hdr_size_q, hdr_size_d;
  logic [31:0]       code_q, code_d;
  logic [PW-1:0]     param_q, param_d;
  logic [31:0]       rc_q, rc_d;
  logic [BUF_AW-1:0] len_q, len_d;
  logic [31:0]       rsp_size_q, rsp_size_d;
  logic [3:0]        hdr_cnt_q, hdr_cnt_d;

  logic              fetch_start, fetch_clear, fetch_rd_en, fetch_vld, fetch_last;
  logic [BUF_AW-1:0] fetch_cnt, fetch_addr, fetch_idx;
  logic              pay_start, pay_clear, pay_rd_en, pay_vld, pay_last;
  logic [BUF_AW-1:0] pay_addr, pay_idx;
  logic [BUF_AW-1:0] len_sat;
  logic [31:0]       err_rc;
  logic [15:0]       rsp_tag;

  // Never read past the header+parameter window, even for large commands
  assign fetch_cnt   = (cmd_size > 32'(FETCH_MAX)) ? BUF_AW'(FETCH_MAX) : cmd_size[BUF_AW-1:0];
  assign fetch_start = (state_q == ST_IDLE) && cmd_start && (cmd_size != 32'd0);
  assign fetch_clear = (state_q == ST_FETCH) && cmd_abort;
  assign pay_start   = (state_q == ST_RSP_HDR) && (hdr_cnt_q == 4'd9) && (len_q != '0) && !cmd_abort;
  assign pay_clear   = (state_q == ST_RSP_PAY) && cmd_abort;
  assign len_sat     = (exec_rsp_len > LEN_MAX) ? LEN_MAX : exec_rsp_len;

  crb_byte_seq #(.AW(BUF_AW)) u_fetch_seq (
    .clock       (clock),
    .reset_n     (reset_n),
    .start_i     (fetch_start),
    .clear_i     (fetch_clear),
    .count_i     (fetch_cnt),
    .rd_en_o     (fetch_rd_en),
    .rd_addr_o   (fetch_addr),
    .cap_valid_o (fetch_vld),
    .cap_idx_o   (fetch_idx),
    .last_o      (fetch_last)
  );

  crb_byte_seq #(.AW(BUF_AW)) u_pay_seq (
    .clock       (clock),
    .reset_n     (reset_n),
    .start_i     (pay_start),
    .clear_i     (pay_clear),
    .count_i     (len_q),
    .rd_en_o     (pay_rd_en),
    .rd_addr_o   (pay_addr),
    .cap_valid_o (pay_vld),
    .cap_idx_o   (pay_idx),
    .last_o      (pay_last)
  );

  // Header validation, first failing check wins
  always_comb begin
    err_rc = RC_SUCCESS;
    if (int'(loc_q) >= NUM_LOC) begin
      err_rc = RC_LOCALITY;
    end else if ((size_q < 32'(HDR_LEN)) || ({1'b0, size_q} > DEPTH_W)) begin
      err_rc = RC_COMMAND_SIZE;
    end else if ((tag_q != TAG_NO_SESSIONS) && (tag_q != TAG_SESSIONS)) begin
      err_rc = RC_BAD_TAG;
    end else if (hdr_size_q != size_q) begin
      err_rc = RC_COMMAND_SIZE;
    end
  end

  // Next-state: byte capture during FETCH plus the main control FSM
  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    loc_d      = loc_q;
    tag_d      = tag_q;
    hdr_size_d = hdr_size_q;
    code_d     = code_q;
    param_d    = param_q;
    rc_d       = rc_q;
    len_d      = len_q;
    rsp_size_d = rsp_size_q;
    hdr_cnt_d  = hdr_cnt_q;

    if (fetch_vld) begin
      for (int b = 0; b < 2; b++)
        if (fetch_idx == BUF_AW'(b)) tag_d[15-8*b -: 8] = cmd_rd_data;
      for (int b = 0; b < 4; b++)
        if (fetch_idx == BUF_AW'(2 + b)) hdr_size_d[31-8*b -: 8] = cmd_rd_data;
      for (int b = 0; b < 4; b++)
        if (fetch_idx == BUF_AW'(6 + b)) code_d[31-8*b -: 8] = cmd_rd_data;
      for (int p = 0; p < PARAM_BYTES; p++)
        if (fetch_idx == BUF_AW'(HDR_LEN + p)) param_d[PW-1-8*p -: 8] = cmd_rd_data;
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_start) begin
          size_d     = cmd_size;
          loc_d      = locality;
          tag_d      = '0;
          hdr_size_d = '0;
          code_d     = '0;
          param_d    = '0;
          rc_d       = '0;
          len_d      = '0;
          rsp_size_d = '0;
          state_d    = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (cmd_abort) state_d = ST_ABORT;
        else if ((size_q == 32'd0) || fetch_last) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (cmd_abort) begin
          state_d = ST_ABORT;
        end else if (err_rc != RC_SUCCESS) begin
          rc_d       = err_rc;
          len_d      = '0;
          rsp_size_d = 32'(HDR_LEN);
          hdr_cnt_d  = '0;
          state_d    = ST_RSP_HDR;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cmd_abort) begin
          state_d = ST_ABORT;
        end else if (exec_ack) begin
          rc_d       = exec_rc;
          len_d      = len_sat;
          rsp_size_d = 32'(HDR_LEN) + 32'(len_sat);
          hdr_cnt_d  = '0;
          state_d    = ST_RSP_HDR;
        end
      end
      ST_RSP_HDR: begin
        if (cmd_abort) begin
          state_d = ST_ABORT;
        end else if (hdr_cnt_q == 4'd9) begin
          state_d = (len_q == '0) ? ST_DONE : ST_RSP_PAY;
        end else begin
          hdr_cnt_d = hdr_cnt_q + 4'd1;
        end
      end
      ST_RSP_PAY: begin
        if (cmd_abort) state_d = ST_ABORT;
        else if (pay_last) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ABORT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (state_d == ST_ABORT) rsp_size_d = '0;
  end

  // State and latched-field registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      size_q     <= '0;
      loc_q      <= '0;
      tag_q      <= '0;
      hdr_size_q <= '0;
      code_q     <= '0;
      param_q    <= '0;
      rc_q       <= '0;
      len_q      <= '0;
      rsp_size_q <= '0;
      hdr_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      loc_q      <= loc_d;
      tag_q      <= tag_d;
      hdr_size_q <= hdr_size_d;
      code_q     <= code_d;
      param_q    <= param_d;
      rc_q       <= rc_d;
      len_q      <= len_d;
      rsp_size_q <= rsp_size_d;
      hdr_cnt_q  <= hdr_cnt_d;
    end
  end

  // Failed commands always answer with the no-sessions tag
  assign rsp_tag = (rc_q == RC_SUCCESS) ? tag_q : TAG_NO_SESSIONS;

  // Response write port: header bytes from registers, payload bytes straight from the source
  always_comb begin
    rsp_wr_en   = 1'b0;
    rsp_wr_addr = '0;
    rsp_wr_data = '0;
    if (state_q == ST_RSP_HDR) begin
      rsp_wr_en   = 1'b1;
      rsp_wr_addr = BUF_AW'(hdr_cnt_q);
      case (hdr_cnt_q)
        4'd0:                      rsp_wr_data = rsp_tag[15:8];
        4'd1:                      rsp_wr_data = rsp_tag[7:0];
        4'd2, 4'd3, 4'd4, 4'd5:    rsp_wr_data = be_byte(rsp_size_q, 2'(hdr_cnt_q - 4'd2));
        default:                   rsp_wr_data = be_byte(rc_q, 2'(hdr_cnt_q - 4'd6));
      endcase
    end else if ((state_q == ST_RSP_PAY) && pay_vld) begin
      rsp_wr_en   = 1'b1;
      rsp_wr_addr = pay_idx + BUF_AW'(HDR_LEN);
      rsp_wr_data = pl_rd_data;
    end
  end

  assign cmd_rd_en     = fetch_rd_en;
  assign cmd_rd_addr   = fetch_rd_en ? fetch_addr : '0;
  assign pl_rd_addr    = pay_rd_en ? pay_addr : '0;
  assign exec_req      = (state_q == ST_EXEC);
  assign exec_tag      = tag_q;
  assign exec_code     = code_q;
  assign exec_locality = loc_q;
  assign exec_param    = param_q;
  assign rsp_size      = rsp_size_q;
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);
  assign aborted       = (state_q == ST_ABORT);

endmodule

// File: tb/tb_tpm_crb_engine.sv
// Scoreboard bench for tpm_crb_engine: stimulus pushes expected writes, exec
// fields and completion sizes; a forked monitor pops and compares them.
module tb_tpm_crb_engine;

  localparam int BUF_AW = 12;
  localparam int DEPTH  = 4096;

  logic              clk;
  logic              reset_n;
  logic              cmd_start;
  logic [31:0]       cmd_size;
  logic [2:0]        locality;
  logic              cmd_abort;
  logic              cmd_rd_en;
  logic [BUF_AW-1:0] cmd_rd_addr;
  logic [7:0]        cmd_rd_data;
  logic              exec_req;
  logic [15:0]       exec_tag;
  logic [31:0]       exec_code;
  logic [2:0]        exec_locality;
  logic [39:0]       exec_param;
  logic              exec_ack;
  logic [31:0]       exec_rc;
  logic [BUF_AW-1:0] exec_rsp_len;
  logic [BUF_AW-1:0] pl_rd_addr;
  logic [7:0]        pl_rd_data;
  logic              rsp_wr_en;
  logic [BUF_AW-1:0] rsp_wr_addr;
  logic [7:0]        rsp_wr_data;
  logic [31:0]       rsp_size;
  logic              busy;
  logic              done;
  logic              aborted;

  tpm_crb_engine #(.BUF_AW(BUF_AW), .NUM_LOC(5), .PARAM_BYTES(5)) dut (
    .clock         (clk),
    .reset_n       (reset_n),
    .cmd_start     (cmd_start),
    .cmd_size      (cmd_size),
    .locality      (locality),
    .cmd_abort     (cmd_abort),
    .cmd_rd_en     (cmd_rd_en),
    .cmd_rd_addr   (cmd_rd_addr),
    .cmd_rd_data   (cmd_rd_data),
    .exec_req      (exec_req),
    .exec_tag      (exec_tag),
    .exec_code     (exec_code),
    .exec_locality (exec_locality),
    .exec_param    (exec_param),
    .exec_ack      (exec_ack),
    .exec_rc       (exec_rc),
    .exec_rsp_len  (exec_rsp_len),
    .pl_rd_addr    (pl_rd_addr),
    .pl_rd_data    (pl_rd_data),
    .rsp_wr_en     (rsp_wr_en),
    .rsp_wr_addr   (rsp_wr_addr),
    .rsp_wr_data   (rsp_wr_data),
    .rsp_size      (rsp_size),
    .busy          (busy),
    .done          (done),
    .aborted       (aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer models with 1-cycle read latency
  logic [7:0] cmd_mem [0:DEPTH-1];
  logic [7:0] pl_mem  [0:DEPTH-1];
  always @(posedge clk) begin
    if (cmd_rd_en) cmd_rd_data <= cmd_mem[cmd_rd_addr];
    pl_rd_data <= pl_mem[pl_rd_addr];
  end

  typedef struct packed {
    logic [BUF_AW-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  typedef struct packed {
    logic [15:0] tag;
    logic [31:0] code;
    logic [2:0]  loc;
    logic [39:0] param;
  } exec_t;

  wr_t         exp_wr[$];
  exec_t       exp_exec[$];
  logic [31:0] exp_done[$];
  logic [31:0] exp_abort[$];

  int                errors;
  int                checks;
  logic [BUF_AW-1:0] prev_pl_addr;
  logic              prev_req;
  logic [BUF_AW-1:0] last_wr_addr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got=%0h expected=none", name, act);
  endtask

  task automatic monitor();
    wr_t   w;
    exec_t e;
    forever begin
      @(negedge clk);
      if (rsp_wr_en) begin
        if (exp_wr.size() == 0) begin
          unexpected("unexpected_write", 64'({rsp_wr_addr, rsp_wr_data}));
        end else begin
          w = exp_wr.pop_front();
          check("wr_addr", 64'(rsp_wr_addr), 64'(w.addr));
          check("wr_data", 64'(rsp_wr_data), 64'(w.data));
          $display("write addr=%0d data=%02h", rsp_wr_addr, rsp_wr_data);
        end
        if (rsp_wr_addr >= 12'd10) check("pl_lead", 64'(prev_pl_addr), 64'(rsp_wr_addr - 12'd10));
        last_wr_addr = rsp_wr_addr;
      end
      if (exec_req && !prev_req) begin
        if (exp_exec.size() == 0) begin
          unexpected("unexpected_exec", 64'(exec_code));
        end else begin
          e = exp_exec.pop_front();
          check("exec_tag", 64'(exec_tag), 64'(e.tag));
          check("exec_code", 64'(exec_code), 64'(e.code));
          check("exec_loc", 64'(exec_locality), 64'(e.loc));
          check("exec_param", 64'(exec_param), 64'(e.param));
          $display("exec tag=%04h code=%08h loc=%0d param=%010h", exec_tag, exec_code, exec_locality, exec_param);
        end
      end
      if (done) begin
        if (exp_done.size() == 0) unexpected("unexpected_done", 64'(rsp_size));
        else check("done_rsp_size", 64'(rsp_size), 64'(exp_done.pop_front()));
        $display("done rsp_size=%0d", rsp_size);
      end
      if (aborted) begin
        if (exp_abort.size() == 0) unexpected("unexpected_abort", 64'(rsp_size));
        else check("abort_rsp_size", 64'(rsp_size), 64'(exp_abort.pop_front()));
        $display("aborted rsp_size=%0d", rsp_size);
      end
      prev_pl_addr = pl_rd_addr;
      prev_req     = exec_req;
    end
  endtask

  task automatic set_cmd(input logic [15:0] tag, input logic [31:0] hsize, input logic [31:0] code,
                         input logic [7:0] p0, input logic [7:0] p1);
    cmd_mem[0]  = tag[15:8];
    cmd_mem[1]  = tag[7:0];
    cmd_mem[2]  = hsize[31:24];
    cmd_mem[3]  = hsize[23:16];
    cmd_mem[4]  = hsize[15:8];
    cmd_mem[5]  = hsize[7:0];
    cmd_mem[6]  = code[31:24];
    cmd_mem[7]  = code[23:16];
    cmd_mem[8]  = code[15:8];
    cmd_mem[9]  = code[7:0];
    cmd_mem[10] = p0;
    cmd_mem[11] = p1;
    cmd_mem[12] = 8'hEE;
    cmd_mem[13] = 8'hEE;
    cmd_mem[14] = 8'hEE;
  endtask

  task automatic push_hdr(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
                          input logic [7:0] b6, input logic [7:0] b7, input logic [7:0] b8,
                          input logic [7:0] b9);
    exp_wr.push_back('{12'd0, b0});
    exp_wr.push_back('{12'd1, b1});
    exp_wr.push_back('{12'd2, b2});
    exp_wr.push_back('{12'd3, b3});
    exp_wr.push_back('{12'd4, b4});
    exp_wr.push_back('{12'd5, b5});
    exp_wr.push_back('{12'd6, b6});
    exp_wr.push_back('{12'd7, b7});
    exp_wr.push_back('{12'd8, b8});
    exp_wr.push_back('{12'd9, b9});
  endtask

  task automatic run_cmd(input logic [31:0] size, input logic [2:0] loc);
    @(posedge clk) #1;
    cmd_start = 1'b1;
    cmd_size  = size;
    locality  = loc;
    @(posedge clk) #1;
    cmd_start = 1'b0;
  endtask

  task automatic wait_exec(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exec_req) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) unexpected("exec_req_timeout", 64'(exec_req));
  endtask

  task automatic ack(input logic [31:0] rc, input logic [BUF_AW-1:0] len);
    bit ok;
    wait_exec(ok);
    if (ok) begin
      @(posedge clk) #1;
      exec_ack     = 1'b1;
      exec_rc      = rc;
      exec_rsp_len = len;
      @(posedge clk) #1;
      exec_ack     = 1'b0;
      exec_rc      = '0;
      exec_rsp_len = '0;
    end
  endtask

  task automatic wait_idle(input string name);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (!busy) begin
        idle = 1'b1;
        break;
      end
    end
    if (!idle) unexpected(name, 64'(busy));
  endtask

  task automatic check_drained(input string name);
    check({name, "_wr_q"}, 64'(exp_wr.size()), 64'd0);
    check({name, "_done_q"}, 64'(exp_done.size()), 64'd0);
    check({name, "_exec_q"}, 64'(exp_exec.size()), 64'd0);
    check({name, "_abort_q"}, 64'(exp_abort.size()), 64'd0);
  endtask

  task automatic check_all_zero(input string name);
    logic any;
    any = |{cmd_rd_en, cmd_rd_addr, exec_req, exec_tag, exec_code, exec_locality, exec_param,
            pl_rd_addr, rsp_wr_en, rsp_wr_addr, rsp_wr_data, rsp_size, busy, done, aborted};
    check(name, 64'(any), 64'd0);
  endtask

  // Startup-style command, response with empty payload
  task automatic test_startup();
    set_cmd(16'h8001, 32'h0000_000C, 32'h0000_0144, 8'h00, 8'h00);
    exp_exec.push_back('{16'h8001, 32'h0000_0144, 3'd0, 40'h0});
    push_hdr(8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00);
    exp_done.push_back(32'd10);
    run_cmd(32'd12, 3'd0);
    ack(32'h0, 12'd0);
    wait_idle("startup_idle");
    check("startup_rsp_size_held", 64'(rsp_size), 64'd10);
    check_drained("startup");
  endtask

  // Validation failure: no exec request, 10-byte error response with tag 8001
  task automatic test_error(input string name, input logic [15:0] tag, input logic [31:0] hsize,
                            input logic [31:0] size, input logic [2:0] loc, input logic [31:0] rc);
    set_cmd(tag, hsize, 32'h0000_0144, 8'h00, 8'h00);
    push_hdr(8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0A, rc[31:24], rc[23:16], rc[15:8], rc[7:0]);
    exp_done.push_back(32'd10);
    run_cmd(size, loc);
    wait_idle({name, "_idle"});
    check_drained(name);
  endtask

  initial begin
    bit ok;
    errors       = 0;
    checks       = 0;
    reset_n      = 1'b0;
    cmd_start    = 1'b0;
    cmd_size     = '0;
    locality     = '0;
    cmd_abort    = 1'b0;
    exec_ack     = 1'b0;
    exec_rc      = '0;
    exec_rsp_len = '0;
    prev_pl_addr = '0;
    prev_req     = 1'b0;
    last_wr_addr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cmd_mem[i] = 8'h00;
      pl_mem[i]  = 8'(i) ^ 8'h5A;
    end
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_outputs");
    check("reset_exec_tag", 64'(exec_tag), 64'h0);
    @(posedge clk) #2;
    reset_n = 1'b1;

    // 1: startup command
    test_startup();

    // 2: tag 8002 with 6-byte payload
    set_cmd(16'h8002, 32'h0000_000C, 32'h0000_017B, 8'hAA, 8'hBB);
    for (int k = 0; k < 6; k++) pl_mem[k] = 8'h11 + 8'(k);
    exp_exec.push_back('{16'h8002, 32'h0000_017B, 3'd2, 40'hAABB00_0000});
    push_hdr(8'h80, 8'h02, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00);
    for (int k = 0; k < 6; k++) exp_wr.push_back('{12'(10 + k), 8'h11 + 8'(k)});
    exp_done.push_back(32'd16);
    run_cmd(32'd12, 3'd2);
    ack(32'h0, 12'd6);
    wait_idle("payload_idle");
    check_drained("payload");

    // 3..6: validation errors
    test_error("size8", 16'h8001, 32'h0000_0008, 32'd8, 3'd0, 32'h0000_0142);
    test_error("loc5", 16'h8001, 32'h0000_000C, 32'd12, 3'd5, 32'h0000_0907);
    test_error("badtag", 16'hC1C1, 32'h0000_000C, 32'd12, 3'd0, 32'h0000_001E);
    test_error("hdrsize", 16'h8001, 32'h0000_000E, 32'd12, 3'd0, 32'h0000_0142);

    // 7: oversize payload length saturates so the response fills the buffer exactly
    for (int k = 0; k < DEPTH; k++) pl_mem[k] = 8'(k) ^ 8'h5A;
    set_cmd(16'h8001, 32'h0000_000C, 32'h0000_017B, 8'h01, 8'h02);
    exp_exec.push_back('{16'h8001, 32'h0000_017B, 3'd1, 40'h0102_000000});
    push_hdr(8'h80, 8'h01, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    for (int k = 0; k < DEPTH - 10; k++) exp_wr.push_back('{12'(10 + k), 8'(k) ^ 8'h5A});
    exp_done.push_back(32'd4096);
    run_cmd(32'd12, 3'd1);
    ack(32'h0, 12'hFFF);
    wait_idle("full_idle");
    check("full_last_addr", 64'(last_wr_addr), 64'd4095);
    check_drained("full");

    // 8: abort while waiting for execution
    set_cmd(16'h8001, 32'h0000_000C, 32'h0000_0144, 8'h00, 8'h00);
    exp_exec.push_back('{16'h8001, 32'h0000_0144, 3'd0, 40'h0});
    run_cmd(32'd12, 3'd0);
    wait_exec(ok);
    @(posedge clk) #1;
    cmd_abort = 1'b1;
    exp_abort.push_back(32'd0);
    @(posedge clk) #1;
    cmd_abort = 1'b0;
    @(negedge clk);
    check("abort_exec_req", 64'(exec_req), 64'd0);
    check("abort_pulse", 64'(aborted), 64'd1);
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_pulse_end", 64'(aborted), 64'd0);
    check_drained("abort");

    // 9: abort in the same cycle as exec_ack
    exp_exec.push_back('{16'h8001, 32'h0000_0144, 3'd0, 40'h0});
    run_cmd(32'd12, 3'd0);
    wait_exec(ok);
    @(posedge clk) #1;
    cmd_abort    = 1'b1;
    exec_ack     = 1'b1;
    exec_rc      = 32'h0;
    exec_rsp_len = 12'd4;
    exp_abort.push_back(32'd0);
    @(posedge clk) #1;
    cmd_abort    = 1'b0;
    exec_ack     = 1'b0;
    exec_rsp_len = '0;
    @(negedge clk);
    check("abortack_exec_req", 64'(exec_req), 64'd0);
    check("abortack_rsp_size", 64'(rsp_size), 64'd0);
    @(negedge clk);
    check("abortack_busy", 64'(busy), 64'd0);
    check_drained("abortack");

    // 10: asynchronous reset in the middle of a payload copy
    set_cmd(16'h8002, 32'h0000_000C, 32'h0000_017B, 8'hAA, 8'hBB);
    exp_exec.push_back('{16'h8002, 32'h0000_017B, 3'd2, 40'hAABB00_0000});
    push_hdr(8'h80, 8'h02, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00);
    for (int k = 0; k < 6; k++) exp_wr.push_back('{12'(10 + k), 8'(k) ^ 8'h5A});
    run_cmd(32'd12, 3'd2);
    ack(32'h0, 12'd6);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rsp_wr_en && (rsp_wr_addr == 12'd12)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) unexpected("reset_mid_timeout", 64'(rsp_wr_addr));
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset_outputs");
    exp_wr.delete();
    exp_done.delete();
    repeat (2) @(posedge clk);
    #2;
    check_all_zero("held_reset_outputs");
    reset_n = 1'b1;
    check_drained("reset_mid");

    // 11: normal operation after the reset
    test_startup();

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
